// File: rtl/floo_axis_vc_credit_ctrl.sv
// Per-VC credit flow control between the NoC/AXIS bridge and the serial link.
// Forwards beats only against remote credit; batches local FIFO pops into credit-return messages.
module floo_axis_vc_credit_ctrl #(
  parameter int unsigned NumCredits = 3,
  parameter int unsigned DataWidth  = 64,
  localparam int unsigned CntWidth  = $clog2(NumCredits + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DataWidth-1:0]  in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DataWidth-1:0]  out_data_o,
  input  logic [1:0]            credit_rtn_i,
  input  logic [1:0]            consumed_i,
  output logic                  crd_valid_o,
  input  logic                  crd_ready_i,
  output logic                  crd_vc_o,
  output logic [CntWidth-1:0]   crd_count_o,
  output logic [2*CntWidth-1:0] credits_o,
  output logic                  overflow_o
);

  localparam int unsigned SumWidth = CntWidth + 1;
  localparam logic [SumWidth-1:0] MaxSum = SumWidth'(NumCredits);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);

  logic                 r_out_valid;
  logic [DataWidth-1:0] r_out_data;
  logic                 r_crd_valid;
  logic                 r_crd_vc;
  logic [CntWidth-1:0]  r_crd_count;
  logic                 r_rr;
  logic                 r_overflow;
  logic [CntWidth-1:0]  r_credit  [2];
  logic [CntWidth-1:0]  r_pending [2];

  logic                 w_vc;
  logic                 w_out_free;
  logic                 w_accept;
  logic                 w_crd_free;
  logic                 w_any_pend;
  logic                 w_crd_sel;
  logic                 w_crd_load;
  logic                 w_ovf_set;
  logic [SumWidth-1:0]  w_cred_sum [2];
  logic [SumWidth-1:0]  w_pend_sum [2];
  logic [CntWidth-1:0]  w_lat_amt  [2];
  logic [CntWidth-1:0]  w_credit_nxt  [2];
  logic [CntWidth-1:0]  w_pending_nxt [2];

  // Outgoing beat handshake: header bit selects the VC whose credit gates the beat
  assign w_vc       = in_data_i[DataWidth-1];
  assign w_out_free = !r_out_valid | out_ready_i;
  assign in_ready_o = w_out_free & (r_credit[w_vc] != '0);
  assign w_accept   = in_valid_i & in_ready_o;

  // Credit-return arbitration: single nonzero VC wins, otherwise round-robin
  assign w_crd_free = !r_crd_valid | crd_ready_i;
  assign w_any_pend = (r_pending[0] != '0) | (r_pending[1] != '0);
  assign w_crd_sel  = ((r_pending[0] != '0) && (r_pending[1] != '0)) ? r_rr
                                                                     : (r_pending[1] != '0);
  assign w_crd_load = w_crd_free & w_any_pend;

  // Saturating counter updates; any attempt to exceed the FIFO depth is flagged
  always_comb begin
    w_ovf_set = 1'b0;
    for (int v = 0; v < 2; v++) begin
      w_lat_amt[v]     = (w_crd_load && (w_crd_sel == 1'(v))) ? r_pending[v] : '0;
      w_cred_sum[v]    = SumWidth'(r_credit[v])
                       - SumWidth'(w_accept && (w_vc == 1'(v)))
                       + SumWidth'(credit_rtn_i[v]);
      w_pend_sum[v]    = SumWidth'(r_pending[v]) - SumWidth'(w_lat_amt[v])
                       + SumWidth'(consumed_i[v]);
      w_credit_nxt[v]  = CntWidth'(w_cred_sum[v]);
      w_pending_nxt[v] = CntWidth'(w_pend_sum[v]);
      if (w_cred_sum[v] > MaxSum) begin
        w_credit_nxt[v] = MaxCnt;
        w_ovf_set       = 1'b1;
      end
      if (w_pend_sum[v] > MaxSum) begin
        w_pending_nxt[v] = MaxCnt;
        w_ovf_set        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_crd_valid <= 1'b0;
      r_crd_vc    <= 1'b0;
      r_crd_count <= '0;
      r_rr        <= 1'b0;
      r_overflow  <= 1'b0;
      for (int v = 0; v < 2; v++) begin
        r_credit[v]  <= MaxCnt;
        r_pending[v] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data_i;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (w_crd_load) begin
        r_crd_valid <= 1'b1;
        r_crd_vc    <= w_crd_sel;
        r_crd_count <= r_pending[w_crd_sel];
        r_rr        <= !w_crd_sel;
      end else if (w_crd_free) begin
        r_crd_valid <= 1'b0;
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
      for (int v = 0; v < 2; v++) begin
        r_credit[v]  <= w_credit_nxt[v];
        r_pending[v] <= w_pending_nxt[v];
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign crd_valid_o = r_crd_valid;
  assign crd_vc_o    = r_crd_vc;
  assign crd_count_o = r_crd_count;
  assign credits_o   = {r_credit[1], r_credit[0]};
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_floo_axis_vc_credit_ctrl.sv
// Bench for floo_axis_vc_credit_ctrl: directed scenarios plus random traffic,
// every cycle compared against an integer-level model of the credit rules.
module tb_floo_axis_vc_credit_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [1:0]    credit_rtn_i;
  logic [1:0]    consumed_i;
  logic          crd_valid_o;
  logic          crd_ready_i;
  logic          crd_vc_o;
  logic [CW-1:0] crd_count_o;
  logic [2*CW-1:0] credits_o;
  logic          overflow_o;

  floo_axis_vc_credit_ctrl #(.NumCredits(N), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .credit_rtn_i(credit_rtn_i), .consumed_i(consumed_i),
    .crd_valid_o(crd_valid_o), .crd_ready_i(crd_ready_i), .crd_vc_o(crd_vc_o),
    .crd_count_o(crd_count_o), .credits_o(credits_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state in plain integers
  int            m_cred [2];
  int            m_pend [2];
  int            m_rr;
  bit            m_ovf;
  bit            m_ov;
  logic [DW-1:0] m_od;
  bit            m_cv;
  int            m_cvc;
  int            m_ccnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_cred[v] = N;
      m_pend[v] = 0;
    end
    m_rr = 0; m_ovf = 0; m_ov = 0; m_od = '0; m_cv = 0; m_cvc = 0; m_ccnt = 0;
  endtask

  function automatic bit model_ready();
    int vc;
    vc = int'(in_data_i[DW-1]);
    return (!m_ov || out_ready_i) && (m_cred[vc] != 0);
  endfunction

  task automatic model_step();
    int  vc, ch, n;
    bit  acc;
    int  lat [2];
    vc  = int'(in_data_i[DW-1]);
    acc = in_valid_i && model_ready();
    lat[0] = 0; lat[1] = 0;
    if (acc) begin
      m_ov = 1; m_od = in_data_i;
    end else if (out_ready_i) begin
      m_ov = 0;
    end
    if (!m_cv || crd_ready_i) begin
      if (m_pend[0] != 0 || m_pend[1] != 0) begin
        if (m_pend[0] != 0 && m_pend[1] != 0) ch = m_rr;
        else ch = (m_pend[1] != 0) ? 1 : 0;
        m_cv = 1; m_cvc = ch; m_ccnt = m_pend[ch]; lat[ch] = m_pend[ch]; m_rr = 1 - ch;
      end else begin
        m_cv = 0;
      end
    end
    for (int v = 0; v < 2; v++) begin
      n = m_cred[v] - ((acc && vc == v) ? 1 : 0) + int'(credit_rtn_i[v]);
      if (n > N) begin n = N; m_ovf = 1; end
      m_cred[v] = n;
      n = m_pend[v] - lat[v] + int'(consumed_i[v]);
      if (n > N) begin n = N; m_ovf = 1; end
      m_pend[v] = n;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid_o), 64'(m_ov));
    check("out_data",  out_data_o, m_od);
    check("crd_valid", 64'(crd_valid_o), 64'(m_cv));
    check("crd_vc",    64'(crd_vc_o), 64'(m_cvc));
    check("crd_count", 64'(crd_count_o), 64'(m_ccnt));
    check("credits",   64'(credits_o), 64'({CW'(m_cred[1]), CW'(m_cred[0])}));
    check("overflow",  64'(overflow_o), 64'(m_ovf));
  endtask

  // One clock: apply inputs at the falling edge, check ready, compare registers next falling edge
  task automatic cycle(input bit iv, input logic [DW-1:0] d, input bit ordy,
                       input logic [1:0] rtn, input logic [1:0] cons, input bit crdy);
    in_valid_i = iv; in_data_i = d; out_ready_i = ordy;
    credit_rtn_i = rtn; consumed_i = cons; crd_ready_i = crdy;
    #1;
    if (iv) check("in_ready", 64'(in_ready_o), 64'(model_ready()));
    model_step();
    @(negedge clk_i);
    check_outputs();
  endtask

  function automatic logic [DW-1:0] beat(input bit vc, input int tag);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    d[DW-1] = vc;
    d[15:0] = 16'(tag);
    return d;
  endfunction

  task automatic random_cycles(input int cnt);
    logic [1:0] rtn, cons;
    for (int i = 0; i < cnt; i++) begin
      for (int v = 0; v < 2; v++) begin
        rtn[v]  = (m_cred[v] < N) && ($urandom_range(3) == 0);
        cons[v] = (m_pend[v] < N) && ($urandom_range(2) == 0);
      end
      cycle($urandom_range(3) != 0, beat(1'($urandom_range(1)), i),
            $urandom_range(3) != 0, rtn, cons, 1'($urandom_range(1)));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    in_valid_i = 1'b0; out_ready_i = 1'b0; credit_rtn_i = '0; consumed_i = '0; crd_ready_i = 1'b0;
    model_reset();
    #1;
    check("rst_credits",   64'(credits_o), 64'({CW'(N), CW'(N)}));
    check("rst_out_valid", 64'(out_valid_o), 64'(0));
    check("rst_crd_valid", 64'(crd_valid_o), 64'(0));
    check("rst_overflow",  64'(overflow_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  logic [DW-1:0] d4;

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    credit_rtn_i = '0; consumed_i = '0; crd_ready_i = 1'b0;
    apply_reset();
    check_outputs();

    // Rsp credit exhaustion and refill
    for (int i = 0; i < 3; i++) cycle(1, beat(0, i), 1, 2'b00, 2'b00, 0);
    check("rsp_exhausted", 64'(credits_o), 64'({CW'(N), CW'(0)}));
    d4 = beat(0, 4);
    cycle(1, d4, 1, 2'b01, 2'b00, 0);
    cycle(1, d4, 1, 2'b00, 2'b00, 0);
    check("fourth_fwd", out_data_o, d4);
    check("fourth_credit", 64'(credits_o), 64'({CW'(N), CW'(0)}));

    // Simultaneous accept and return leaves the count unchanged
    cycle(0, beat(0, 5), 1, 2'b01, 2'b00, 0);
    cycle(1, beat(0, 6), 1, 2'b01, 2'b00, 0);
    check("net_zero", 64'(credits_o), 64'({CW'(N), CW'(1)}));

    // Output backpressure holds the beat
    for (int i = 0; i < 5; i++) cycle(1, beat(1, 10 + i), 0, 2'b00, 2'b00, 0);
    check("bp_rdy_low", 64'(in_ready_o), 64'(0));

    // Credit messages under backpressure, then drained
    cycle(0, '0, 1, 2'b00, 2'b01, 0);
    cycle(0, '0, 1, 2'b00, 2'b01, 0);
    cycle(0, '0, 1, 2'b00, 2'b01, 0);
    cycle(0, '0, 1, 2'b00, 2'b10, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 2'b00, 2'b00, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 2'b00, 2'b00, 1);
    check("crd_drained", 64'(crd_valid_o), 64'(0));

    // Return at full credit saturates and sets the sticky flag
    cycle(0, '0, 1, 2'b10, 2'b00, 1);
    check("ovf_set", 64'(overflow_o), 64'(1));
    check("ovf_cred", 64'(credits_o[2*CW-1:CW]), 64'(N));
    random_cycles(100);
    check("ovf_sticky", 64'(overflow_o), 64'(1));

    apply_reset();
    check_outputs();
    random_cycles(400);
    apply_reset();
    check_outputs();
    random_cycles(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
